// File: rtl/sram_dp_be.sv
// sram_dp_be: simple-dual-port synchronous SRAM with per-byte write enables, a registered
// read port, selectable read-during-write behaviour and a post-reset clear engine.
module sram_dp_be #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 5,
  parameter int RD_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                req_drop
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_rd_valid;
  logic                r_req_drop;

  logic                w_busy;
  logic                w_clr_we;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_collide;
  logic [ADDR_W-1:0]   w_mem_addr;

  // State register: reset restarts the clear sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_addr == '1) begin
          w_state_next = S_READY;
        end
      end
      S_READY: begin
        w_state_next = S_READY;
      end
      default: begin
        w_state_next = S_READY;
      end
    endcase
  end

  // Output / acceptance logic; nothing touches the array during the reset cycle itself.
  always_comb begin
    w_busy     = (r_state == S_CLEAR);
    w_clr_we   = w_busy & ~rst;
    w_wr_acc   = wr_en & ~w_busy & ~rst;
    w_rd_acc   = rd_en & ~w_busy & ~rst;
    w_collide  = w_wr_acc & w_rd_acc & (wr_addr == rd_addr);
    w_mem_addr = w_busy ? r_clr_addr : wr_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_req_drop <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_req_drop <= (wr_en | rd_en) & w_busy;
    end
  end

  // One independent byte-wide RAM per lane so each byte enable maps onto its own write strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_rd_byte;
      logic [7:0] w_wr_byte;
      logic       w_we;

      assign w_we      = w_clr_we | (w_wr_acc & wr_be[gi]);
      assign w_wr_byte = w_clr_we ? 8'h00 : wr_data[gi*8 +: 8];

      always_ff @(posedge clk) begin
        if (w_we) begin
          r_mem[w_mem_addr] <= w_wr_byte;
        end
      end

      // Write-first forwards the incoming byte; otherwise the array gives the pre-write value.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_byte <= 8'h00;
        end else if (w_rd_acc) begin
          if ((RD_MODE != 0) && w_collide && wr_be[gi]) begin
            r_rd_byte <= wr_data[gi*8 +: 8];
          end else begin
            r_rd_byte <= r_mem[rd_addr];
          end
        end
      end

      assign rd_data[gi*8 +: 8] = r_rd_byte;
    end
  endgenerate

  assign rd_valid = r_rd_valid;
  assign busy     = w_busy;
  assign req_drop = r_req_drop;

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: three instances (read-first, write-first, no-clear) share stimulus;
// expected read words are queued on issue and popped when rd_valid returns.
module tb_sram_dp_be;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data_a, rd_data_b, rd_data_c;
  logic          rd_valid_a, rd_valid_b, rd_valid_c;
  logic          busy_a, busy_b, busy_c;
  logic          req_drop_a, req_drop_b, req_drop_c;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic [DW-1:0] q_c[$];

  always #5 clk = ~clk;

  sram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .CLEAR_ON_RST(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .req_drop(req_drop_a));

  sram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .CLEAR_ON_RST(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .req_drop(req_drop_b));

  sram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .CLEAR_ON_RST(0)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .busy(busy_c), .req_drop(req_drop_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_be = 2'b00;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    $display("txn wr addr=%0d data=%h be=%b", a, d, be);
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    rd_en   = 1'b1;
    rd_addr = a;
    q_a.push_back(ea);
    q_b.push_back(eb);
    $display("txn rd addr=%0d expect_a=%h expect_b=%h", a, ea, eb);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    checks++;
    if (busy_a !== 1'b1 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy_a=%b busy_c=%b, required 1 and 0", busy_a, busy_c);
    end
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 16'h0000 || req_drop_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h drop=%b, required 0/0000/0",
               rd_valid_a, rd_data_a, req_drop_a);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_clear_sweep();
    logic [DW-1:0] exp;
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (busy_a !== (n < 16)) begin
        errors++;
        $display("FAIL clear_busy edge %0d: busy=%b, required %b", n, busy_a, (n < 16));
      end
    end
    for (int i = 0; i < 16; i++) begin
      issue_read(AW'(i), 16'h0000, 16'h0000);
      step();
      checks++;
      if (rd_valid_a !== 1'b1 || q_a.size() == 0) begin
        errors++;
        $display("FAIL clear_read addr %0d: valid=%b, required 1", i, rd_valid_a);
      end else begin
        exp = q_a.pop_front();
        if (rd_data_a !== exp) begin
          errors++;
          $display("FAIL clear_read addr %0d: data=%h, required %h", i, rd_data_a, exp);
        end
      end
      void'(q_b.pop_front());
    end
    idle();
    step();
    checks++;
    if (rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_valid_drop: valid=%b, required 0", rd_valid_a);
    end
  endtask

  task automatic test_byte_enables();
    logic [DW-1:0] exp;
    issue_write(4'd3, 16'hA5C3, 2'b11);
    step();
    issue_write(4'd3, 16'h1234, 2'b01);
    step();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        issue_write(4'd3, 16'hFFFF, 2'b00);
        step();
      end
      idle();
      issue_read(4'd3, 16'hA534, 16'hA534);
      step();
      checks++;
      if (rd_valid_a !== 1'b1 || q_a.size() == 0) begin
        errors++;
        $display("FAIL be_read_a pass %0d: valid=%b, required 1", k, rd_valid_a);
      end else begin
        exp = q_a.pop_front();
        if (rd_data_a !== exp) begin
          errors++;
          $display("FAIL be_read_a pass %0d: data=%h, required %h", k, rd_data_a, exp);
        end
      end
      checks++;
      if (rd_valid_b !== 1'b1 || q_b.size() == 0) begin
        errors++;
        $display("FAIL be_read_b pass %0d: valid=%b, required 1", k, rd_valid_b);
      end else begin
        exp = q_b.pop_front();
        if (rd_data_b !== exp) begin
          errors++;
          $display("FAIL be_read_b pass %0d: data=%h, required %h", k, rd_data_b, exp);
        end
      end
      idle();
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp;
    issue_write(4'd5, 16'h1111, 2'b11);
    step();
    issue_write(4'd5, 16'h2222, 2'b10);
    issue_read(4'd5, 16'h1111, 16'h2211);
    step();
    idle();
    issue_read(4'd5, 16'h2211, 16'h2211);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) step();
      checks++;
      if (rd_valid_a !== 1'b1 || q_a.size() == 0) begin
        errors++;
        $display("FAIL collide_a read %0d: valid=%b, required 1", k, rd_valid_a);
      end else begin
        exp = q_a.pop_front();
        if (rd_data_a !== exp) begin
          errors++;
          $display("FAIL collide_a read %0d: data=%h, required %h", k, rd_data_a, exp);
        end
      end
      checks++;
      if (rd_valid_b !== 1'b1 || q_b.size() == 0) begin
        errors++;
        $display("FAIL collide_b read %0d: valid=%b, required 1", k, rd_valid_b);
      end else begin
        exp = q_b.pop_front();
        if (rd_data_b !== exp) begin
          errors++;
          $display("FAIL collide_b read %0d: data=%h, required %h", k, rd_data_b, exp);
        end
      end
    end
    idle();
  endtask

  task automatic test_busy_access();
    logic [DW-1:0] exp;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = 16'hBEEF;
    wr_be   = 2'b11;
    rd_en   = 1'b1;
    rd_addr = 4'd2;
    $display("txn busy wr+rd addr=2 data=beef");
    step();
    idle();
    checks++;
    if (req_drop_a !== 1'b1 || rd_valid_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop: drop=%b valid=%b busy=%b, required 1/0/1", req_drop_a, rd_valid_a, busy_a);
    end
    for (int n = 4; n <= 16; n++) begin
      step();
      if (n == 4) begin
        checks++;
        if (req_drop_a !== 1'b0) begin
          errors++;
          $display("FAIL busy_drop_pulse: drop=%b, required 0", req_drop_a);
        end
      end
      checks++;
      if (busy_a !== (n < 16)) begin
        errors++;
        $display("FAIL busy_clear edge %0d: busy=%b, required %b", n, busy_a, (n < 16));
      end
    end
    issue_read(4'd2, 16'h0000, 16'h0000);
    step();
    idle();
    checks++;
    if (rd_valid_a !== 1'b1 || q_a.size() == 0) begin
      errors++;
      $display("FAIL busy_read: valid=%b, required 1", rd_valid_a);
    end else begin
      exp = q_a.pop_front();
      if (rd_data_a !== exp) begin
        errors++;
        $display("FAIL busy_read: data=%h, required %h", rd_data_a, exp);
      end
    end
    void'(q_b.pop_front());
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] exp;
    issue_write(4'd0, 16'hDEAD, 2'b11);
    step();
    issue_write(4'd9, 16'h5A5A, 2'b11);
    step();
    issue_write(4'd15, 16'hC0DE, 2'b11);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) step();
    rst     = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    step();
    rst = 1'b0;
    idle();
    checks++;
    if (rd_valid_a !== 1'b0 || busy_a !== 1'b1 || rd_data_a !== 16'h0000) begin
      errors++;
      $display("FAIL midclear_rst: valid=%b busy=%b data=%h, required 0/1/0000", rd_valid_a, busy_a, rd_data_a);
    end
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (busy_a !== (n < 16)) begin
        errors++;
        $display("FAIL midclear_busy edge %0d: busy=%b, required %b", n, busy_a, (n < 16));
      end
    end
    for (int i = 0; i < 16; i++) begin
      issue_read(AW'(i), 16'h0000, 16'h0000);
      step();
      checks++;
      if (rd_valid_a !== 1'b1 || q_a.size() == 0) begin
        errors++;
        $display("FAIL midclear_read addr %0d: valid=%b, required 1", i, rd_valid_a);
      end else begin
        exp = q_a.pop_front();
        if (rd_data_a !== exp) begin
          errors++;
          $display("FAIL midclear_read addr %0d: data=%h, required %h", i, rd_data_a, exp);
        end
      end
      void'(q_b.pop_front());
    end
    idle();
  endtask

  task automatic test_retention();
    logic [DW-1:0] exp;
    issue_write(4'd7, 16'h00FF, 2'b11);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy_c !== 1'b0 || rd_data_c !== 16'h0000) begin
      errors++;
      $display("FAIL noclr_reset: busy=%b data=%h, required 0/0000", busy_c, rd_data_c);
    end
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (busy_c !== 1'b0) begin
        errors++;
        $display("FAIL noclr_busy edge %0d: busy=%b, required 0", n, busy_c);
      end
    end
    rd_en   = 1'b1;
    rd_addr = 4'd7;
    q_c.push_back(16'h00FF);
    $display("txn rd_c addr=7 expect=00ff");
    step();
    idle();
    checks++;
    if (rd_valid_c !== 1'b1 || q_c.size() == 0) begin
      errors++;
      $display("FAIL noclr_read: valid=%b, required 1", rd_valid_c);
    end else begin
      exp = q_c.pop_front();
      if (rd_data_c !== exp) begin
        errors++;
        $display("FAIL noclr_read: data=%h, required %h", rd_data_c, exp);
      end
    end
    for (int n = 1; n <= 5; n++) begin
      step();
      checks++;
      if (rd_data_c !== 16'h00FF || rd_valid_c !== 1'b0) begin
        errors++;
        $display("FAIL noclr_hold cycle %0d: data=%h valid=%b, required 00ff/0", n, rd_data_c, rd_valid_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_byte_enables();
    test_collision();
    test_busy_access();
    test_reset_mid_clear();
    test_retention();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left a=%0d b=%0d c=%0d, required 0", q_a.size(), q_b.size(), q_c.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_be.md
# sram_dp_be

Parametrised simple-dual-port synchronous SRAM, the successor to the 8x32 single-port scratch memory. It has an independent write port with per-byte enables and an independent registered read port. It also has a selectable read-during-write collision mode and a built-in clear engine that zeroes the array after reset. It sits as a generic buffer or scratch store behind any block needing one write and one read per cycle.

## Interface
- DATA_W, default 8: word width in bits; must be a multiple of 8.
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W words.
- RD_MODE, default 0: read-during-write to the same address. 0 = read-first (old data); 1 = write-first (new merged data).
- CLEAR_ON_RST, default 1: 1 = zero the whole array after every reset; 0 = contents survive reset.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- busy  out  1  clear engine active; requests are not accepted.
- req_drop  out  1  one-cycle pulse when a request arrived while busy.

## Operation
- State machine with states CLEAR and READY.
  - rst=1: next state is CLEAR if CLEAR_ON_RST=1, otherwise READY. The clear address is set to 0.
  - CLEAR: each cycle write all-zero to the clear address (ignoring wr_be), then increment it. After writing address DEPTH-1, go to READY.
  - READY: stays in READY until rst.
- busy = (state == CLEAR), registered.
- Write in READY: when wr_en=1, only the bytes with wr_be[i]=1 are updated. wr_be=0 is a legal no-op.
- Read in READY: when rd_en=1, rd_data <= mem[rd_addr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value (it is not zeroed).
- Collision: rd_en and wr_en in the same cycle with rd_addr == wr_addr.
  - RD_MODE=0: returns the pre-write word.
  - RD_MODE=1: returns the merged word (enabled bytes from wr_data, other bytes from the old word).
  - In both modes the array is updated.
- Requests while busy:
  - wr_en is discarded and the array is not modified.
  - rd_en produces no rd_valid.
  - req_drop <= 1 next cycle if (wr_en | rd_en) & busy.
- All addresses are in range, because DEPTH is a power of two.

## Timing
- Reset values (in the cycle after rst is sampled high):
  - rd_data = 0, rd_valid = 0, req_drop = 0.
  - busy = 1 if CLEAR_ON_RST, else 0.
- Clear duration: busy stays high for exactly DEPTH cycles after the first edge with rst=0. The first accepted request is on edge DEPTH+1 after rst is released.
- Read latency: 1 cycle. With rd_en sampled at edge k, rd_data and rd_valid are valid after edge k, and rd_valid drops after edge k+1 unless rd_en is still high. Back-to-back reads give one word per cycle.
- Write latency: data written at edge k is visible to a read sampled at edge k+1. At edge k itself, RD_MODE decides.
- Reset mid-clear: the clear engine restarts from address 0 and runs a full DEPTH cycles.
- Reset mid-read: a rd_valid that would have followed is suppressed.
- With CLEAR_ON_RST=0, the array is untouched by reset.

## Test plan
All scenarios use DATA_W=16, ADDR_W=4 (DEPTH=16).
1. Clear sweep: rst high 2 cycles, then low -> busy=1 for exactly 16 cycles then 0. Reads of addresses 0..15 return 0x0000, each with rd_valid 1 cycle after rd_en.
2. Byte enables:
   - Write addr 3 = 0xA5C3 with be=2'b11, then addr 3 = 0x1234 with be=2'b01 -> read addr 3 = 0xA534.
   - Write with be=2'b00 -> read still 0xA534.
3. Collision: addr 5 holds 0x1111; in the same cycle write 0x2222 (be=2'b10) and read addr 5.
   - RD_MODE=0 returns 0x1111; RD_MODE=1 returns 0x2211.
   - A following read returns 0x2211 in both modes.
4. Access while busy: at clear cycle 3, wr_en with addr 2 = 0xBEEF, plus rd_en -> req_drop=1 next cycle and no rd_valid. After clear, addr 2 reads 0x0000.
5. Reset mid-clear: assert rst at clear cycle 8 for 1 cycle -> busy stays high for a full 16 cycles after release, and all words read 0x0000.
6. CLEAR_ON_RST=0 retention and hold:
   - Write addr 7 = 0x00FF, pulse rst -> busy never rises and addr 7 reads 0x00FF.
   - Then rd_en=0 for 5 cycles -> rd_data stays 0x00FF and rd_valid stays 0.
